// File: rtl/prog_counter.sv
// Parametrised up/down counter with programmable step and limit, wrap/saturate
// selection, a registered terminal-value detect flag and a sticky overflow flag.
module prog_counter #(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              preload,
    input  logic [SIZE-1:0]   preload_data,
    input  logic              mode,
    input  logic              wrap,
    input  logic [STEP_W-1:0] step,
    input  logic [SIZE-1:0]   limit,
    output logic              detect,
    output logic              overflow,
    output logic [SIZE-1:0]   result
);

    // One spare bit above the wider operand so sums and limit+1 never truncate.
    localparam int unsigned W = ((SIZE > STEP_W) ? SIZE : STEP_W) + 1;

    logic [SIZE-1:0] result_q, result_d;
    logic            detect_q, detect_d;
    logic            overflow_q, overflow_d;

    logic [W-1:0] res_x, lim_x, lim_p1, step_x, pd_x, es, nxt;

    assign res_x  = W'(result_q);
    assign lim_x  = W'(limit);
    assign pd_x   = W'(preload_data);
    assign step_x = W'(step);
    assign lim_p1 = lim_x + W'(1);
    assign es     = (step_x < lim_p1) ? step_x : lim_p1;

    always_comb begin
        result_d   = result_q;
        overflow_d = overflow_q;
        detect_d   = 1'b0;
        nxt        = '0;
        if (preload) begin
            result_d   = (pd_x > lim_x) ? limit : preload_data;
            overflow_d = 1'b0;
        end else if (enable && (es != '0)) begin
            if (res_x > lim_x) begin
                // Limit was lowered below the current count: clamp to it.
                result_d   = limit;
                overflow_d = 1'b1;
                detect_d   = ~mode;
            end else if (!mode) begin
                nxt = res_x + es;
                if (nxt > lim_x) begin
                    overflow_d = 1'b1;
                    nxt        = wrap ? (nxt - lim_p1) : lim_x;
                end
                result_d = nxt[SIZE-1:0];
                detect_d = (nxt == lim_x);
            end else begin
                if (res_x >= es) begin
                    nxt = res_x - es;
                end else begin
                    overflow_d = 1'b1;
                    nxt        = wrap ? (res_x + lim_p1 - es) : '0;
                end
                result_d = nxt[SIZE-1:0];
                detect_d = (nxt == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            detect_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            detect_q   <= detect_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign detect   = detect_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios plus a randomised
// back-to-back run, all checked against a queue of expected {result, detect, overflow}.
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       reset, enable, preload, mode, wrap;
    logic [7:0] preload_data, step, limit;
    logic       detect, overflow;
    logic [7:0] result;

    logic [9:0] sb[$];
    int checks = 0;
    int errors = 0;

    prog_counter #(.SIZE(8), .STEP_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .preload      (preload),
        .preload_data (preload_data),
        .mode         (mode),
        .wrap         (wrap),
        .step         (step),
        .limit        (limit),
        .detect       (detect),
        .overflow     (overflow),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic pl, input logic en, input logic md, input logic wr,
                         input logic [7:0] pd, input logic [7:0] st, input logic [7:0] lim);
        preload = pl; enable = en; mode = md; wrap = wr;
        preload_data = pd; step = st; limit = lim;
    endtask

    // Drive one row, push its expectation, clock it and compare.
    task automatic test_reset;
        logic [9:0] e;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 8'd255);
        #2;
        sb.push_back({8'd0, 1'b0, 1'b0});
        e = sb.pop_front();
        checks++;
        if ({result, detect, overflow} !== e) begin
            errors++;
            $display("FAIL reset_init: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                     result, detect, overflow, e[9:2], e[1], e[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_midcount;
        logic [9:0] e;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd255);
        for (int i = 1; i <= 5; i++) begin
            sb.push_back({8'(i), 1'b0, 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({result, detect, overflow} !== e) begin
                errors++;
                $display("FAIL count_up_%0d: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                         i, result, detect, overflow, e[9:2], e[1], e[0]);
            end
        end
        reset = 1'b1;
        #2;
        sb.push_back({8'd0, 1'b0, 1'b0});
        e = sb.pop_front();
        checks++;
        if ({result, detect, overflow} !== e) begin
            errors++;
            $display("FAIL async_reset: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                     result, detect, overflow, e[9:2], e[1], e[0]);
        end
        reset = 1'b0;
        sb.push_back({8'd1, 1'b0, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({result, detect, overflow} !== e) begin
            errors++;
            $display("FAIL resume_after_reset: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                     result, detect, overflow, e[9:2], e[1], e[0]);
        end
    endtask

    task automatic test_up_wrap;
        logic [9:0] e;
        logic [7:0] exp_r [6] = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2, 8'd5};
        logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_o [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 8'd9);
            else        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd3, 8'd9);
            sb.push_back({exp_r[i], exp_d[i], exp_o[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({result, detect, overflow} !== e) begin
                errors++;
                $display("FAIL up_wrap_%0d: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                         i, result, detect, overflow, e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_down_saturate;
        logic [9:0] e;
        logic [7:0] exp_r [7] = '{8'd7, 8'd5, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_d [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd7, 8'd2, 8'd9);
            else if (i == 6) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd7, 8'd2, 8'd9);
            else             drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 8'd2, 8'd9);
            sb.push_back({exp_r[i], exp_d[i], exp_o[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({result, detect, overflow} !== e) begin
                errors++;
                $display("FAIL down_sat_%0d: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                         i, result, detect, overflow, e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_down_wrap_and_preload;
        logic [9:0] e;
        // Rows: preload 1; wrap down to 8; preload 50 clamped to 20 with enable;
        // step 0 holds.
        logic       pl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       md [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] pd [4] = '{8'd1, 8'd1, 8'd50, 8'd50};
        logic [7:0] st [4] = '{8'd3, 8'd3, 8'd3, 8'd0};
        logic [7:0] lm [4] = '{8'd9, 8'd9, 8'd20, 8'd20};
        logic [7:0] exp_r [4] = '{8'd1, 8'd8, 8'd20, 8'd20};
        logic       exp_o [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(pl[i], (i != 0), md[i], 1'b1, pd[i], st[i], lm[i]);
            sb.push_back({exp_r[i], 1'b0, exp_o[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({result, detect, overflow} !== e) begin
                errors++;
                $display("FAIL wrap_preload_%0d: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                         i, result, detect, overflow, e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_edge_cases;
        logic [9:0] e;
        logic       pl [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] pd [7] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd2};
        logic [7:0] st [7] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd255, 8'd255};
        logic [7:0] lm [7] = '{8'd20, 8'd20, 8'd20, 8'd20, 8'd10, 8'd3, 8'd3};
        logic [7:0] exp_r [7] = '{8'd0, 8'd5, 8'd10, 8'd15, 8'd10, 8'd2, 8'd2};
        logic       exp_d [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(pl[i], 1'b1, 1'b0, 1'b1, pd[i], st[i], lm[i]);
            sb.push_back({exp_r[i], exp_d[i], exp_o[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({result, detect, overflow} !== e) begin
                errors++;
                $display("FAIL edge_%0d: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                         i, result, detect, overflow, e[9:2], e[1], e[0]);
            end
        end
    endtask

    // Random stimulus every cycle, expectations from a behavioural integer model.
    task automatic test_back_to_back;
        logic [9:0] e;
        int mr = 0;
        int mo = 0;
        int md = 0;
        for (int i = 0; i < 80; i++) begin
            logic pl, en, mm, wr;
            int pd, st, lim, es, s;
            pl  = (i == 0) || ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 5) != 0);
            mm  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            pd  = int'($urandom_range(0, 255));
            st  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 6));
            lim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 20));
            md = 0;
            if (pl) begin
                mr = (pd > lim) ? lim : pd;
                mo = 0;
            end else if (en) begin
                es = (st < lim + 1) ? st : lim + 1;
                if (es > 0) begin
                    if (mr > lim) begin
                        mr = lim; mo = 1; md = mm ? 0 : 1;
                    end else if (!mm) begin
                        s = mr + es;
                        if (s > lim) begin mo = 1; s = wr ? s - lim - 1 : lim; end
                        mr = s; md = (mr == lim) ? 1 : 0;
                    end else begin
                        s = mr - es;
                        if (s < 0) begin mo = 1; s = wr ? s + lim + 1 : 0; end
                        mr = s; md = (mr == 0) ? 1 : 0;
                    end
                end
            end
            drive(pl, en, mm, wr, 8'(pd), 8'(st), 8'(lim));
            sb.push_back({8'(mr), 1'(md), 1'(mo)});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({result, detect, overflow} !== e) begin
                errors++;
                $display("FAIL random_%0d: result=%0d detect=%b overflow=%b, expected %0d %b %b",
                         i, result, detect, overflow, e[9:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midcount();
        test_up_wrap();
        test_down_saturate();
        test_down_wrap_and_preload();
        test_edge_cases();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Next-generation parametrised counter. It replaces the fixed 4-bit up/down counter with one that has:
- configurable width
- programmable step and programmable terminal limit
- wrap or saturate selection
- a sticky overflow flag
It sits under the same program-based testbench flow and keeps the existing enable/preload/mode/detect/result port set, so current testcases still drive it.

Parameters:
SIZE, 8, counter/result/limit/preload width in bits.
STEP_W, 8, width of step input.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count enable
preload  input  1  synchronous load of preload_data
preload_data  input  SIZE  load value
mode  input  1  0 = count up, 1 = count down
wrap  input  1  1 = wrap at bounds, 0 = saturate at bounds
step  input  STEP_W  increment/decrement amount
limit  input  SIZE  upper bound; legal count range is 0..limit
detect  output  1  registered flag: count update landed on terminal value
overflow  output  1  sticky: a wrap or saturation event occurred
result  output  SIZE  current count

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. On reset assertion, with no clock edge needed: result=0, detect=0, overflow=0.
- All outputs are registered and update on the clk rising edge. Latency is one cycle from input to result.
- Priority: reset > preload > enable > hold.
- preload=1:
  - result <= min(preload_data, limit)
  - overflow <= 0; detect <= 0
  - enable is ignored
- enable=0 and preload=0: result and overflow hold; detect <= 0.
- Effective step: es = min(step, limit+1). Compute in max(SIZE, STEP_W)+1 bits, so no intermediate truncation.
- step==0 with enable: result holds; detect <= 0; overflow unchanged.
- Out-of-range (limit changed below result), enable=1, es>0:
  - result <= limit; overflow <= 1
  - detect <= 1 if mode=0, else 0
- Up count (mode=0), with s = result + es:
  - s <= limit: result <= s.
  - s > limit and wrap=1: result <= s - (limit+1); overflow <= 1.
  - s > limit and wrap=0: result <= limit; overflow <= 1.
- Down count (mode=1):
  - result >= es: result <= result - es.
  - result < es and wrap=1: result <= result + (limit+1) - es; overflow <= 1.
  - result < es and wrap=0: result <= 0; overflow <= 1.
- detect is asserted for exactly the cycle after an enabled, es>0 update whose new result equals the terminal value (limit when mode=0, 0 when mode=1). This includes repeated saturation at the terminal value, so detect stays high while pinned.
- overflow is set only by the events listed above, is never cleared by counting, and is cleared only by reset or preload.
- mode, wrap, step and limit may change on any cycle and take effect on the next edge.
- limit=0: range is {0}. Every enabled nonzero step keeps result=0, sets overflow and asserts detect.
- Reset asserted mid-count overrides everything. Counting resumes from 0 on the first edge after deassertion.

Test Plan:
1. SIZE=8; up, step=1, limit=255; count to 5, then pulse reset between edges -> result, detect and overflow all 0 before the next edge; next enabled edge gives result=1.
2. limit=9, step=3, wrap=1, mode=0, from 0 -> results 3, 6, 9 (detect=1), then 2 (overflow=1, detect=0), then 5; overflow stays 1.
3. Preload 7, then mode=1, step=2, wrap=0 -> 5, 3, 1, 0 (detect=1, overflow=1), then 0 (detect=1 again); enable=0 -> detect=0, result=0.
4. limit=9, preload 1, mode=1, step=3, wrap=1 -> result 8, overflow=1, detect=0.
5. limit=20, preload_data=50, preload=1 with enable=1 and overflow previously 1 -> result=20, overflow=0, detect=0. Then mode=0, step=0 -> result holds at 20, detect=0.
6. Two edge cases:
   - Count to 15 with limit=20, then set limit=10 with enable=1 -> result=10, overflow=1, detect=1.
   - limit=3, step=255, wrap=1, up, from 2 -> es=4, result stays 2 with overflow=1.
